// File: rtl/mem_write_checker_pkg.sv
// Shared types and constants for the data-memory write-stream checker.
// Optional run-end logging is enabled by defining MEM_WRITE_CHECKER_LOG_EN.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mwc_exp_table.sv
// Expected-store table: N_EXP entries of {address, data}, one synchronous
// write port and one combinational read port. Contents survive reset.
module mwc_exp_table #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int N_EXP = 4,
    parameter int IW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [IW-1:0] ridx,
    output logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [AW-1:0] addr_mem [N_EXP];
    logic [DW-1:0] data_mem [N_EXP];

    logic widx_ok;
    logic ridx_ok;

    assign widx_ok = (32'(widx) < N_EXP);
    assign ridx_ok = (32'(ridx) < N_EXP);

    // Out-of-range indices are dropped on write and read back as zero.
    always_ff @(posedge clk) begin
        if (we && widx_ok) begin
            addr_mem[widx] <= waddr;
            data_mem[widx] <= wdata;
        end
    end

    assign raddr = ridx_ok ? addr_mem[ridx] : '0;
    assign rdata = ridx_ok ? data_mem[ridx] : '0;

endmodule

// File: rtl/mem_write_checker.sv
// In-order checker of the core's store stream against a loadable table.
// Define MEM_WRITE_CHECKER_LOG_EN for simulation-only PASS/FAIL logging.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int          AW          = 32,
    parameter int          DW          = 32,
    parameter int          N_EXP       = 4,
    parameter int          TIMEOUT     = 1024,
    parameter int unsigned IGNORE_ADDR = 80,
    localparam int         IW          = (N_EXP > 1) ? $clog2(N_EXP) : 1,
    localparam int         CW          = $clog2(N_EXP + 1),
    localparam int         TW          = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          memwrite,
    input  logic [AW-1:0] dataadr,
    input  logic [DW-1:0] writedata,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    output logic          busy,
    output logic          pass,
    output logic          fail,
    output logic [1:0]    fail_code,
    output logic [AW-1:0] fail_addr,
    output logic [DW-1:0] fail_data,
    output logic [CW-1:0] match_cnt,
    output logic [15:0]   ign_cnt,
    output logic [TW-1:0] cyc_cnt,
    output logic [1:0]    state_dbg
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_PASS = PASS;
    localparam logic [1:0] S_FAIL = FAIL;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;
    logic          tbl_we;
    logic          is_ign;
    logic          is_hit;
    logic          is_miss;
    logic          ptr_last;
    logic          cyc_last;
    logic          done;

    // The table is frozen while a run is in progress.
    assign tbl_we = exp_we && (state != S_RUN);

    mwc_exp_table #(
        .AW    (AW),
        .DW    (DW),
        .N_EXP (N_EXP),
        .IW    (IW)
    ) u_tbl (
        .clk   (clk),
        .we    (tbl_we),
        .widx  (exp_idx),
        .waddr (exp_addr),
        .wdata (exp_data),
        .ridx  (ptr),
        .raddr (t_addr),
        .rdata (t_data)
    );

    // Scratch-address writes take priority even when the table holds that address.
    assign is_ign   = memwrite && (dataadr == AW'(IGNORE_ADDR));
    assign is_hit   = memwrite && !is_ign && (dataadr == t_addr) && (writedata == t_data);
    assign is_miss  = memwrite && !is_ign && !is_hit;
    assign ptr_last = (32'(ptr) == N_EXP - 1);
    assign cyc_last = (32'(cyc_cnt) == TIMEOUT - 1);
    assign done     = is_hit && ptr_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            match_cnt <= '0;
            ign_cnt   <= '0;
            cyc_cnt   <= '0;
            fail_code <= FC_NONE;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (!cyc_last) begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    if (is_ign) begin
                        ign_cnt <= sat_inc16(ign_cnt);
                    end
                    if (is_hit) begin
                        ptr       <= ptr + 1'b1;
                        match_cnt <= match_cnt + 1'b1;
                    end
                    // A completing match beats timeout; a mismatch beats timeout.
                    if (done) begin
                        state <= S_PASS;
                    end else if (is_miss) begin
                        state     <= S_FAIL;
                        fail_code <= FC_MISMATCH;
                        fail_addr <= dataadr;
                        fail_data <= writedata;
                    end else if (cyc_last) begin
                        state     <= S_FAIL;
                        fail_code <= FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        state     <= S_RUN;
                        ptr       <= '0;
                        match_cnt <= '0;
                        ign_cnt   <= '0;
                        cyc_cnt   <= '0;
                        fail_code <= FC_NONE;
                        fail_addr <= '0;
                        fail_data <= '0;
                    end
                end
            endcase
        end
    end

    assign busy      = (state == S_RUN);
    assign pass      = (state == S_PASS);
    assign fail      = (state == S_FAIL);
    assign state_dbg = state;

`ifdef MEM_WRITE_CHECKER_LOG_EN
    always @(posedge clk) begin
        if (reset && (state == S_RUN)) begin
            if (done) begin
                $display("LOG:Simulation succeeded match_cnt=%0d ign_cnt=%0d cyc_cnt=%0d",
                         match_cnt + 1'b1, ign_cnt, cyc_last ? cyc_cnt : cyc_cnt + 1'b1);
            end else if (is_miss || cyc_last) begin
                $display("LOG:Simulation failed fail_code=%0d fail_addr=%0h fail_data=%0h exp_addr=%0h exp_data=%0h",
                         is_miss ? FC_MISMATCH : FC_TIMEOUT,
                         is_miss ? dataadr : {AW{1'b0}},
                         is_miss ? writedata : {DW{1'b0}},
                         t_addr, t_data);
                $stop;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: a default-timeout and a TIMEOUT=16 instance share
// one stimulus stream; each is compared with a sequence-level reference model.
module tb_mem_write_checker;

    typedef struct {
        int          fin_k;
        int          pass;
        int          fail;
        int          code;
        logic [31:0] fa;
        logic [31:0] fd;
        int          match;
        int          ign;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;

    logic        a_busy, a_pass, a_fail, b_busy, b_pass, b_fail;
    logic [1:0]  a_code, b_code, a_st, b_st;
    logic [31:0] a_fa, a_fd, b_fa, b_fd;
    logic [2:0]  a_match, b_match;
    logic [15:0] a_ign, b_ign;
    logic [10:0] a_cyc;
    logic [4:0]  b_cyc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tbl_a [4];
    logic [31:0] tbl_d [4];
    bit          sq_we [$];
    logic [31:0] sq_a  [$];
    logic [31:0] sq_d  [$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_write_checker u_dut_a (
        .clk(clk), .reset(rst_n), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(a_busy), .pass(a_pass),
        .fail(a_fail), .fail_code(a_code), .fail_addr(a_fa), .fail_data(a_fd),
        .match_cnt(a_match), .ign_cnt(a_ign), .cyc_cnt(a_cyc), .state_dbg(a_st)
    );

    mem_write_checker #(.TIMEOUT(16)) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .busy(b_busy), .pass(b_pass),
        .fail(b_fail), .fail_code(b_code), .fail_addr(b_fa), .fail_data(b_fd),
        .match_cnt(b_match), .ign_cnt(b_ign), .cyc_cnt(b_cyc), .state_dbg(b_st)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the store list in order; entry k is seen on the k-th cycle in RUN.
    task automatic model(input int tmo, output res_t r);
        int  ptr;
        int  cyc_pre;
        bit  we;
        bit  fin;
        logic [31:0] a, d;
        r = '{fin_k: 0, pass: 0, fail: 0, code: 0, fa: 32'd0, fd: 32'd0, match: 0, ign: 0, cyc: 0};
        ptr = 0;
        fin = 0;
        for (int k = 0; k <= tmo && !fin; k++) begin
            we = (k < sq_we.size()) ? sq_we[k] : 1'b0;
            a  = (k < sq_a.size()) ? sq_a[k] : 32'd0;
            d  = (k < sq_d.size()) ? sq_d[k] : 32'd0;
            cyc_pre = r.cyc;
            if (we && a == 32'd80) begin
                if (r.ign < 65535) r.ign++;
            end else if (we && a == tbl_a[ptr] && d == tbl_d[ptr]) begin
                ptr++;
                if (ptr == 4) begin
                    r.pass = 1;
                    fin = 1;
                end
            end else if (we) begin
                r.fail = 1; r.code = 1; r.fa = a; r.fd = d;
                fin = 1;
            end
            if (!fin && cyc_pre == tmo - 1) begin
                r.fail = 1; r.code = 2;
                fin = 1;
            end
            r.cyc = (cyc_pre == tmo - 1) ? cyc_pre : cyc_pre + 1;
            if (fin) r.fin_k = k;
        end
        r.match = ptr;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        exp_we = 1'b1; exp_idx = 2'(idx); exp_addr = a; exp_data = d;
        @(negedge clk);
        exp_we = 1'b0;
        tbl_a[idx] = a;
        tbl_d[idx] = d;
    endtask

    task automatic push(input bit we, input logic [31:0] a, input logic [31:0] d);
        sq_we.push_back(we);
        sq_a.push_back(a);
        sq_d.push_back(d);
    endtask

    task automatic clear_seq();
        sq_we.delete();
        sq_a.delete();
        sq_d.delete();
    endtask

    task automatic chk_final(input string p, input res_t r, input logic ps, input logic fl,
                             input logic [1:0] code, input logic [31:0] fa, input logic [31:0] fd,
                             input int m, input int ig, input int cy);
        chk({p, "_pass"}, 32'(ps), 32'(r.pass));
        chk({p, "_fail"}, 32'(fl), 32'(r.fail));
        chk({p, "_code"}, 32'(code), 32'(r.code));
        chk({p, "_faddr"}, fa, r.fa);
        chk({p, "_fdata"}, fd, r.fd);
        chk({p, "_match"}, 32'(m), 32'(r.match));
        chk({p, "_ign"}, 32'(ig), 32'(r.ign));
        chk({p, "_cyc"}, 32'(cy), 32'(r.cyc));
    endtask

    // Start, replay the store list one entry per cycle, optionally poke the table mid-run.
    task automatic run_scenario(input string tag, input int inj_k);
        res_t ra, rb;
        int   last;
        model(1024, ra);
        model(16, rb);
        last = ((ra.fin_k > rb.fin_k) ? ra.fin_k : rb.fin_k) + 2;
        @(negedge clk);
        start = 1'b1; memwrite = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_a_busy0"}, 32'(a_busy), 32'd1);
        chk({tag, "_b_busy0"}, 32'(b_busy), 32'd1);
        for (int k = 0; k <= last; k++) begin
            if (k < sq_we.size()) begin
                memwrite = sq_we[k]; dataadr = sq_a[k]; writedata = sq_d[k];
            end else begin
                memwrite = 1'b0;
            end
            exp_we = (k == inj_k); exp_idx = 2'd0; exp_addr = 32'd88; exp_data = 32'd9;
            @(negedge clk);
            chk({tag, "_a_busy"}, 32'(a_busy), 32'(k < ra.fin_k));
            chk({tag, "_b_busy"}, 32'(b_busy), 32'(k < rb.fin_k));
        end
        memwrite = 1'b0;
        exp_we = 1'b0;
        chk_final({tag, "_a"}, ra, a_pass, a_fail, a_code, a_fa, a_fd, int'(a_match), int'(a_ign), int'(a_cyc));
        chk_final({tag, "_b"}, rb, b_pass, b_fail, b_code, b_fa, b_fd, int'(b_match), int'(b_ign), int'(b_cyc));
    endtask

    task automatic gen_rand();
        int gp;
        int r;
        int len;
        clear_seq();
        gp = 0;
        len = $urandom_range(0, 14);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       push(1'b0, 32'd84, 32'd0);
            else if (r == 2) push(1'b1, 32'd80, 32'($urandom_range(0, 255)));
            else if (r == 3) push(1'b1, 32'd80 + 32'(4 * $urandom_range(1, 3)), 32'($urandom_range(0, 3)));
            else begin
                push(1'b1, tbl_a[gp % 4], tbl_d[gp % 4]);
                gp++;
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_st", 32'(a_st), 32'd0);
        chk("rst_a_flags", {29'd0, a_busy, a_pass, a_fail}, 32'd0);
        chk("rst_a_cnt", {a_match, a_ign, a_cyc[4:0]}, 32'd0);
        chk("rst_b_code", 32'(b_code), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) load(i, 32'd84, 32'd7);

        // scratch writes then four good stores
        clear_seq();
        push(1'b1, 32'd80, 32'd3); push(1'b1, 32'd80, 32'd5);
        for (int i = 0; i < 4; i++) push(1'b1, 32'd84, 32'd7);
        run_scenario("t1", -1);
        chk("t1_pass", 32'(a_pass), 32'd1);
        chk("t1_match", 32'(a_match), 32'd4);
        chk("t1_ign", 32'(a_ign), 32'd2);
        chk("t1_fail", 32'(a_fail), 32'd0);

        // data mismatch on the second store
        clear_seq();
        push(1'b1, 32'd84, 32'd7); push(1'b1, 32'd84, 32'd6);
        run_scenario("t2", -1);
        chk("t2_code", 32'(a_code), 32'd1);
        chk("t2_faddr", a_fa, 32'd84);
        chk("t2_fdata", a_fd, 32'd6);
        chk("t2_match", 32'(a_match), 32'd1);

        // no stores: short instance times out
        clear_seq();
        run_scenario("t3", -1);
        chk("t3_code", 32'(b_code), 32'd2);
        chk("t3_cyc", 32'(b_cyc), 32'd15);

        // final match lands on the timeout cycle
        clear_seq();
        for (int i = 0; i < 3; i++) push(1'b1, 32'd84, 32'd7);
        for (int i = 3; i < 15; i++) push(1'b0, 32'd0, 32'd0);
        push(1'b1, 32'd84, 32'd7);
        run_scenario("t4", -1);
        chk("t4_pass", 32'(b_pass), 32'd1);
        chk("t4_fail", 32'(b_fail), 32'd0);

        // asynchronous reset mid-run, table survives
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; memwrite = 1'b1; dataadr = 32'd84; writedata = 32'd7;
        @(negedge clk);
        @(negedge clk);
        memwrite = 1'b0;
        chk("t5_pre_match", 32'(a_match), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(a_busy), 32'd0);
        chk("t5_match", 32'(a_match), 32'd0);
        chk("t5_cyc", 32'(a_cyc), 32'd0);
        chk("t5_b_st", 32'(b_st), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_seq();
        for (int i = 0; i < 4; i++) push(1'b1, 32'd84, 32'd7);
        run_scenario("t5", -1);
        chk("t5_pass", 32'(a_pass), 32'd1);

        // table write during RUN is dropped; after reload the new entry is checked
        run_scenario("t6", 0);
        chk("t6_pass", 32'(a_pass), 32'd1);
        load(0, 32'd88, 32'd9);
        clear_seq();
        push(1'b1, 32'd88, 32'd9);
        run_scenario("t6b", -1);
        chk("t6b_match", 32'(a_match), 32'd1);

        // random tables and store streams
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++)
                load(i, 32'd80 + 32'(4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)));
            gen_rand();
            run_scenario($sformatf("r%0d", t), ($urandom_range(0, 3) == 0) ? 1 : -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
